// File: rtl/sudoku_bt_solver.sv
// Backtracking Sudoku solver for an N x N grid (N = BOX*BOX): validates the givens, then
// runs a raster-order depth-first search that tries one candidate value per cycle.
module sudoku_bt_solver #(
    parameter  int BOX        = 3,
    parameter  int MAX_CYCLES = 0,
    localparam int N          = BOX * BOX,
    localparam int CELLS      = N * N,
    localparam int CW         = $clog2(N + 1),
    localparam int IW         = $clog2(CELLS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CELLS*CW-1:0] enter,
    output logic                ready_to_start,
    output logic                busy,
    output logic                done,
    output logic [1:0]          status,
    output logic [CELLS*CW-1:0] out,
    output logic [31:0]         cycles
);
    localparam int CIW = $clog2(CELLS);

    typedef enum logic [2:0] {S_IDLE, S_VAL, S_SRCH, S_BACK, S_DONE} state_t;
    localparam logic [1:0] ST_SOLVED = 2'd0, ST_INVALID = 2'd1, ST_UNSOLV = 2'd2, ST_TIMEOUT = 2'd3;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_grid [CELLS];
    logic [CELLS-1:0]    r_given;
    logic [IW-1:0]       r_idx, w_idx_nxt;
    logic [1:0]          r_status, w_status_nxt;
    logic [31:0]         r_cycles, w_cyc_inc;
    logic                w_set_status, w_wr_en, w_tmo, w_busy;
    logic [CW-1:0]       w_wr_val, w_cur, w_cand, w_test;
    logic [CIW-1:0]      w_cell_idx;
    logic                w_idx_ok, w_given_cur, w_conflict, w_val_fail;
    logic [IW-1:0]       w_row, w_col, w_brow, w_bcol;

    assign w_idx_ok    = (r_idx < IW'(CELLS));
    assign w_cell_idx  = r_idx[CIW-1:0];
    assign w_cur       = w_idx_ok ? r_grid[w_cell_idx] : '0;
    assign w_given_cur = w_idx_ok & r_given[w_cell_idx];
    assign w_cand      = w_cur + CW'(1);
    assign w_test      = (r_state == S_VAL) ? w_cur : w_cand;
    assign w_row       = r_idx / IW'(N);
    assign w_col       = r_idx % IW'(N);
    assign w_brow      = w_row / IW'(BOX);
    assign w_bcol      = w_col / IW'(BOX);
    assign w_cyc_inc   = (&r_cycles) ? r_cycles : r_cycles + 32'd1;
    assign w_busy      = (r_state == S_VAL) || (r_state == S_SRCH) || (r_state == S_BACK);
    assign w_tmo       = (MAX_CYCLES != 0) && w_busy && (w_cyc_inc == 32'(MAX_CYCLES));

    // Peer scan: any other nonzero cell in the same row, column or box holding the test value.
    always_comb begin
        w_conflict = 1'b0;
        for (int j = 0; j < CELLS; j++) begin
            if (IW'(j) != r_idx && r_grid[j] != '0 && r_grid[j] == w_test &&
                (IW'(j / N) == w_row || IW'(j % N) == w_col ||
                 (IW'((j / N) / BOX) == w_brow && IW'((j % N) / BOX) == w_bcol)))
                w_conflict = 1'b1;
        end
    end

    assign w_val_fail = w_given_cur && ((w_cur > CW'(N)) || w_conflict);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_wr_en      = 1'b0;
        w_wr_val     = w_cand;
        w_set_status = 1'b0;
        w_status_nxt = ST_SOLVED;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_VAL;
            S_VAL: begin
                if (w_val_fail) begin
                    w_state_nxt  = S_DONE;
                    w_set_status = 1'b1;
                    w_status_nxt = ST_INVALID;
                end else if (r_idx == IW'(CELLS - 1)) begin
                    w_state_nxt = S_SRCH;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + IW'(1);
                end
            end
            S_SRCH: begin
                if (!w_idx_ok) begin
                    w_state_nxt  = S_DONE;
                    w_set_status = 1'b1;
                    w_status_nxt = ST_SOLVED;
                end else if (w_given_cur) begin
                    w_idx_nxt = r_idx + IW'(1);
                end else if (w_cand > CW'(N)) begin
                    w_wr_en  = 1'b1;
                    w_wr_val = '0;
                    if (r_idx == '0) begin
                        w_state_nxt  = S_DONE;
                        w_set_status = 1'b1;
                        w_status_nxt = ST_UNSOLV;
                    end else begin
                        w_state_nxt = S_BACK;
                        w_idx_nxt   = r_idx - IW'(1);
                    end
                end else begin
                    w_wr_en = 1'b1;
                    if (!w_conflict) w_idx_nxt = r_idx + IW'(1);
                end
            end
            S_BACK: begin
                if (w_given_cur) begin
                    if (r_idx == '0) begin
                        w_state_nxt  = S_DONE;
                        w_set_status = 1'b1;
                        w_status_nxt = ST_UNSOLV;
                    end else begin
                        w_idx_nxt = r_idx - IW'(1);
                    end
                end else begin
                    w_state_nxt = S_SRCH;
                end
            end
            S_DONE: if (!start) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // Budget expiry freezes the grid and index and overrides whatever else this edge would do.
        if (w_tmo) begin
            w_state_nxt  = S_DONE;
            w_idx_nxt    = r_idx;
            w_wr_en      = 1'b0;
            w_set_status = 1'b1;
            w_status_nxt = ST_TIMEOUT;
        end
    end

    always_comb begin
        ready_to_start = (r_state == S_IDLE);
        busy           = w_busy;
        done           = (r_state == S_DONE);
        status         = r_status;
        cycles         = r_cycles;
        out            = '0;
        for (int i = 0; i < CELLS; i++) out[(CELLS-1-i)*CW +: CW] = r_grid[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CELLS; i++) r_grid[i] <= '0;
            r_given  <= '0;
            r_idx    <= '0;
            r_status <= ST_SOLVED;
            r_cycles <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                for (int i = 0; i < CELLS; i++) begin
                    r_grid[i]  <= enter[(CELLS-1-i)*CW +: CW];
                    r_given[i] <= |enter[(CELLS-1-i)*CW +: CW];
                end
                r_idx    <= '0;
                r_cycles <= '0;
            end
        end else if (w_busy) begin
            r_cycles <= w_cyc_inc;
            r_idx    <= w_idx_nxt;
            if (w_wr_en)      r_grid[w_cell_idx] <= w_wr_val;
            if (w_set_status) r_status <= w_status_nxt;
        end
    end
endmodule

// File: tb/tb_sudoku_bt_solver.sv
// Randomised bench for sudoku_bt_solver: a plain array-based solver model predicts status,
// cycle count and final grid for 9x9 (unlimited and 50-cycle budget) and 4x4 instances.
module tb_sudoku_bt_solver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         s9, s9t, s4;
    logic [323:0] e9, e9t;
    logic [47:0]  e4;
    logic         r9, b9, d9, r9t, b9t, d9t, r4, b4, d4;
    logic [1:0]   st9, st9t, st4;
    logic [323:0] o9, o9t;
    logic [47:0]  o4;
    logic [31:0]  c9, c9t, c4;

    sudoku_bt_solver #(.BOX(3), .MAX_CYCLES(0)) u_d9 (
        .clk(clk), .rst(rst), .start(s9), .enter(e9), .ready_to_start(r9), .busy(b9),
        .done(d9), .status(st9), .out(o9), .cycles(c9));
    sudoku_bt_solver #(.BOX(3), .MAX_CYCLES(50)) u_d9t (
        .clk(clk), .rst(rst), .start(s9t), .enter(e9t), .ready_to_start(r9t), .busy(b9t),
        .done(d9t), .status(st9t), .out(o9t), .cycles(c9t));
    sudoku_bt_solver #(.BOX(2), .MAX_CYCLES(0)) u_d4 (
        .clk(clk), .rst(rst), .start(s4), .enter(e4), .ready_to_start(r4), .busy(b4),
        .done(d4), .status(st4), .out(o4), .cycles(c4));

    int n_cmp = 0, n_mis = 0;
    int m_puz[81], mg[81], base9[81], m_st, m_cyc;
    bit mgv[81];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic d_done(int s);
        case (s) 0: return d9; 1: return d9t; default: return d4; endcase
    endfunction
    function automatic logic d_busy(int s);
        case (s) 0: return b9; 1: return b9t; default: return b4; endcase
    endfunction
    function automatic logic d_rdy(int s);
        case (s) 0: return r9; 1: return r9t; default: return r4; endcase
    endfunction
    function automatic logic [1:0] d_st(int s);
        case (s) 0: return st9; 1: return st9t; default: return st4; endcase
    endfunction
    function automatic logic [31:0] d_cyc(int s);
        case (s) 0: return c9; 1: return c9t; default: return c4; endcase
    endfunction
    function automatic int d_cell(int s, int i);
        case (s)
            0: return int'(o9[(80-i)*4 +: 4]);
            1: return int'(o9t[(80-i)*4 +: 4]);
            default: return int'(o4[(15-i)*3 +: 3]);
        endcase
    endfunction
    task automatic set_start(int s, logic v);
        case (s) 0: s9 = v; 1: s9t = v; default: s4 = v; endcase
    endtask

    // v is legal at i if no other nonzero cell sharing a row, column or box holds it.
    function automatic bit legal(int bx, int i, int v);
        int n = bx * bx;
        for (int j = 0; j < n * n; j++) begin
            if (j != i && mg[j] != 0 && mg[j] == v &&
                (j / n == i / n || j % n == i % n ||
                 ((j / n) / bx == (i / n) / bx && (j % n) / bx == (i % n) / bx)))
                return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model(input int bx, input int budget);
        int n, c, idx, cyc, v;
        bit back, fin, ok;
        n = bx * bx; c = n * n;
        for (int i = 0; i < 81; i++) begin
            mg[i]  = (i < c) ? m_puz[i] : 0;
            mgv[i] = (mg[i] != 0);
        end
        cyc = 0; fin = 0; m_st = 0;
        for (int i = 0; i < c && !fin; i++) begin
            cyc++;
            if (budget != 0 && cyc == budget) begin m_st = 3; fin = 1; end
            else if (mgv[i] && (mg[i] > n || !legal(bx, i, mg[i]))) begin m_st = 1; fin = 1; end
        end
        idx = 0; back = 0;
        while (!fin) begin
            cyc++;
            if (cyc > 60000) begin m_st = 9; fin = 1; end
            else if (budget != 0 && cyc == budget) begin m_st = 3; fin = 1; end
            else if (!back) begin
                if (idx == c) begin m_st = 0; fin = 1; end
                else if (mgv[idx]) idx++;
                else begin
                    v = mg[idx] + 1;
                    if (v > n) begin
                        mg[idx] = 0;
                        if (idx == 0) begin m_st = 2; fin = 1; end
                        else begin idx--; back = 1; end
                    end else begin
                        ok = legal(bx, idx, v);
                        mg[idx] = v;
                        if (ok) idx++;
                    end
                end
            end else begin
                if (mgv[idx]) begin
                    if (idx == 0) begin m_st = 2; fin = 1; end
                    else idx--;
                end else back = 0;
            end
        end
        m_cyc = cyc;
    endtask

    task automatic run(input int s, input int bx, input int budget, input string nm, input bit hold);
        int c, bc, k, bad;
        model(bx, budget);
        c = (bx * bx) * (bx * bx);
        @(negedge clk);
        for (int i = 0; i < 81; i++) begin
            if (s == 0) e9[(80-i)*4 +: 4] = 4'(m_puz[i]);
            else if (s == 1) e9t[(80-i)*4 +: 4] = 4'(m_puz[i]);
            else if (i < 16) e4[(15-i)*3 +: 3] = 3'(m_puz[i]);
        end
        set_start(s, 1'b1);
        @(negedge clk);
        if (!hold) set_start(s, 1'b0);
        chk({nm, "_busy"}, d_busy(s), 1);
        bc = 0; k = 0;
        while (!d_done(s) && k < m_cyc + 50) begin
            if (d_busy(s)) bc++;
            @(negedge clk);
            k++;
        end
        chk({nm, "_done"}, d_done(s), 1);
        chk({nm, "_status"}, d_st(s), m_st);
        chk({nm, "_cycles"}, d_cyc(s), m_cyc);
        chk({nm, "_busycnt"}, bc, m_cyc);
        bad = 0;
        for (int i = 0; i < c; i++) if (d_cell(s, i) != mg[i]) bad++;
        chk({nm, "_cells_bad"}, bad, 0);
        if (hold) begin
            repeat (4) @(negedge clk);
            chk({nm, "_held_done"}, d_done(s), 1);
            set_start(s, 1'b0);
        end
        @(negedge clk);
        chk({nm, "_idle"}, d_rdy(s), 1);
    endtask

    task automatic load_t1();
        for (int i = 0; i < 81; i++) m_puz[i] = base9[i];
        m_puz[0] = 0;
    endtask

    initial begin
        int row0[9] = '{2, 7, 6, 3, 1, 4, 9, 5, 8};
        int t3e[16] = '{1, 2, 3, 4, 3, 4, 1, 2, 2, 1, 4, 3, 4, 3, 2, 1};
        int perm[9];
        int bad, tmp, p;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) base9[r*9+c] = row0[(c + r*3 + r/3) % 9];
        rst = 1'b1; s9 = 0; s9t = 0; s4 = 0; e9 = '0; e9t = '0; e4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", r9, 1);
        chk("rst_busy", b9, 0);
        chk("rst_done", d9, 0);
        chk("rst_cycles", c9, 0);
        chk("rst_out_zero", (o9 == '0), 1);
        rst = 1'b0;

        load_t1();
        run(0, 3, 0, "t1", 0);
        chk("t1_cell0", d_cell(0, 0), 2);
        chk("t1_cyc_const", d_cyc(0), 164);

        for (int i = 0; i < 81; i++) m_puz[i] = base9[i];
        m_puz[1] = 5;
        run(0, 3, 0, "t2_dup", 0);
        chk("t2_dup_invalid", d_st(0), 1);
        for (int i = 0; i < 81; i++) m_puz[i] = base9[i];
        m_puz[40] = 10;
        run(0, 3, 0, "t2_big", 0);
        chk("t2_big_invalid", d_st(0), 1);

        for (int i = 0; i < 81; i++) m_puz[i] = 0;
        run(2, 2, 0, "t3", 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (d_cell(2, i) != t3e[i]) bad++;
        chk("t3_lex_first", bad, 0);
        chk("t3_solved", d_st(2), 0);

        for (int i = 0; i < 81; i++) m_puz[i] = 0;
        m_puz[1] = 2; m_puz[2] = 3; m_puz[8] = 1; m_puz[12] = 4;
        run(2, 2, 0, "t4", 0);
        chk("t4_unsolvable", d_st(2), 2);
        chk("t4_blank0", d_cell(2, 0), 0);

        load_t1();
        run(1, 3, 50, "t5", 0);
        chk("t5_timeout", d_st(1), 3);
        chk("t5_cyc_const", d_cyc(1), 50);

        load_t1();
        run(0, 3, 0, "t6_hold", 1);

        @(negedge clk);
        for (int i = 0; i < 81; i++) e9[(80-i)*4 +: 4] = 4'(m_puz[i]);
        s9 = 1'b1;
        @(negedge clk);
        s9 = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_midsearch_busy", b9, 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_ready", r9, 1);
        chk("t6_rst_busy", b9, 0);
        chk("t6_rst_done", d9, 0);
        chk("t6_rst_status", st9, 0);
        chk("t6_rst_cycles", c9, 0);
        chk("t6_rst_out", (o9 == '0), 1);
        @(negedge clk);
        rst = 1'b0;
        load_t1();
        run(0, 3, 0, "t6_rerun", 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 81; i++) m_puz[i] = 0;
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 99) < 30) m_puz[i] = $urandom_range(1, 4);
                if ($urandom_range(0, 19) == 0) m_puz[i] = $urandom_range(5, 7);
            end
            run(2, 2, 0, $sformatf("rnd4_%0d", r), 0);
        end

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 9; i++) perm[i] = i + 1;
            for (int i = 8; i > 0; i--) begin
                p = $urandom_range(0, i);
                tmp = perm[i]; perm[i] = perm[p]; perm[p] = tmp;
            end
            for (int i = 0; i < 81; i++) m_puz[i] = perm[base9[i] - 1];
            tmp = $urandom_range(1, 6);
            for (int b = 0; b < tmp; b++) m_puz[$urandom_range(0, 80)] = 0;
            if (r == 3) m_puz[$urandom_range(0, 80)] = $urandom_range(1, 9);
            if (r == 4) run(1, 3, 50, $sformatf("rnd9t_%0d", r), 0);
            else        run(0, 3, 0, $sformatf("rnd9_%0d", r), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
